wb_ram_arbiter: RTL and testbench
=================================

Name: wb_ram_arbiter

Overview:
- Shares one single-port synchronous RAM between two Wishbone classic slave ports.
  - m0: instruction fetch.
  - m1: data load/store.
- The RAM has 1-cycle registered read, read-before-write, and no byte enables. This block sequences each access through a 3-state FSM.
- Sits between the CPU bus masters and the ram instance.
- Grants one master at a time and returns a single-cycle ack to it.

Parameters:
- dat_width, 32, data bus width (matches ram).
- adr_width, 10, word address width (matches ram).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle / strobe / write enable
- m0_adr_i  in  adr_width  master 0 word address
- m0_dat_i  in  dat_width  master 0 write data
- m0_dat_o  out  dat_width  master 0 read data
- m0_ack_o  out  1  master 0 acknowledge
- m1_*  same set as m0_*, for master 1
- ram_adr_o  out  adr_width  to ram adr_i
- ram_dat_o  out  dat_width  to ram dat_i
- ram_we_o  out  1  to ram we_i
- ram_dat_i  in  dat_width  from ram dat_o
- gnt_o  out  1  index of the current or last granted master (debug)

Behaviour:
- Request: mN_req = mN_cyc_i & mN_stb_i.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, pick a winner.
  - Register winner adr, dat and we into adr_q, dat_q, we_q; set gnt_q; go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration (default): fixed priority, m1 over m0.
- ACCESS:
  - ram_adr_o = adr_q, ram_dat_o = dat_q, ram_we_o = we_q & ~rst.
  - The RAM performs the read or write at the next edge. Go to RESP.
- RESP:
  - ack_o of the granted master = 1 for exactly this cycle; the other ack stays 0.
  - Go to IDLE unconditionally. Requests are never sampled in RESP, so a master still holding stb in the ack cycle is not re-served.
- Outputs outside ACCESS:
  - ram_we_o = 0.
  - ram_adr_o, ram_dat_o hold the last registered values.
- Read data: m0_dat_o = m1_dat_o = ram_dat_i, combinational broadcast. It is valid only in the RESP cycle.
- Latency: request sampled at edge E0, RAM access at E1, ack high between E1 and E2. Throughput is one access per 3 cycles.
- Write ack: same timing as a read. The read data returned alongside it is the old RAM content and is don't-care.
- Simultaneous m0 and m1 requests: the winner is served; the loser holds stb and is served in the next round.
- Master deasserting cyc during ACCESS/RESP:
  - The access still completes.
  - Ack is still driven and ignored by the bus.
  - No abort.
- Reset:
  - State = IDLE, adr_q = 0, dat_q = 0, we_q = 0, gnt_q = 0.
  - Both acks = 0, ram_we_o = 0.
  - rst asserted in ACCESS suppresses the write combinationally, so no RAM corruption. No ack is issued.
- Address and data are not re-sampled after IDLE. Masters must hold them stable per Wishbone until ack anyway.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: round-robin arbitration. When both masters request, the master not equal to gnt_q wins. A single requester always wins.
- Undefined: fixed priority m1 > m0 as above.
- All other timing is identical in both builds.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - Master index constants M0 = 0, M1 = 1.
  - Default widths DAT_W = 32, ADR_W = 10.
- Sub-module wb_arb_pick:
  - Pure combinational winner select from req[1:0] and last grant.
  - Contains the WB_ARB_RR_EN variant.
- The FSM and datapath registers stay in wb_ram_arbiter.

Test Plan:
- m0 read adr 0x005, RAM preloaded 0x005 = 0xDEADBEEF → m0_ack_o high exactly 1 cycle, 2 cycles after the request cycle, with m0_dat_o = 0xDEADBEEF; m1_ack_o stays 0.
- m1 write adr 0x3FF data 0x12345678, then m0 read 0x3FF → m0 receives 0x12345678; ram_we_o high for exactly 1 cycle.
- m0 and m1 both request continuously, fixed-priority build → m1 acked every 3 cycles; m0 starves until m1 drops stb, then m0 acked.
- Same stimulus with WB_ARB_RR_EN → acks alternate m1, m0, m1, m0…; each master served once per 6 cycles.
- m1 write 0xAAAA5555 to 0x010 with rst pulsed during ACCESS → no ack; RAM 0x010 keeps its prior value; FSM in IDLE next cycle.
- Master holds stb for 1 cycle after ack (late drop) → no second access or ack; ram_we_o not re-asserted.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone RAM arbiter.
//   state_t : arbiter FSM states
//   M0/M1   : master indices (M0 = instruction fetch, M1 = data load/store)
//   DAT_W/ADR_W : default data and word-address widths, matching the RAM
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int M0    = 0;
  localparam int M1    = 1;
  localparam int DAT_W = 32;
  localparam int ADR_W = 10;
endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner select for the two-master RAM arbiter.
// Optional build macro: WB_ARB_RR_EN
//   undefined : fixed priority, m1 over m0
//   defined   : round-robin; on a tie the master other than i_last wins
// Ports:
//   i_req  [1:0] request per master (bit index = master index)
//   i_last       last granted master
//   o_vld        at least one request present
//   o_gnt        index of the winning master (meaningful when o_vld)
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_vld,
  output logic       o_gnt
);

  always_comb begin
    o_vld = |i_req;
`ifdef WB_ARB_RR_EN
    if (&i_req) o_gnt = ~i_last;
    else        o_gnt = i_req[M1];
`else
    o_gnt = i_req[M1];
`endif
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle registered read,
// read-before-write, no byte enables) between two Wishbone classic slaves.
// Each access runs IDLE -> ACCESS -> RESP, so one access per 3 cycles.
// Optional build macro: WB_ARB_RR_EN (round-robin arbitration, see wb_arb_pick).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i      master N cycle / strobe / write enable
//   mN_adr_i, mN_dat_i       master N word address / write data
//   mN_dat_o, mN_ack_o       master N read data (broadcast) / acknowledge
//   ram_adr_o/dat_o/we_o     to the RAM
//   ram_dat_i                read data from the RAM
//   gnt_o                    current or last granted master (debug)
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int dat_width = DAT_W,
  parameter int adr_width = ADR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [dat_width-1:0] m0_dat_i,
  output logic [dat_width-1:0] m0_dat_o,
  output logic                 m0_ack_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [dat_width-1:0] m1_dat_i,
  output logic [dat_width-1:0] m1_dat_o,
  output logic                 m1_ack_o,
  output logic [adr_width-1:0] ram_adr_o,
  output logic [dat_width-1:0] ram_dat_o,
  output logic                 ram_we_o,
  input  logic [dat_width-1:0] ram_dat_i,
  output logic                 gnt_o
);

  state_t                 r_state, w_next;
  logic [adr_width-1:0]   r_adr;
  logic [dat_width-1:0]   r_dat;
  logic                   r_we;
  logic                   r_gnt;
  logic [1:0]             w_req;
  logic                   w_vld;
  logic                   w_pick;
  logic                   w_take;

  assign w_req[M0] = m0_cyc_i & m0_stb_i;
  assign w_req[M1] = m1_cyc_i & m1_stb_i;

  wb_arb_pick u_pick (
    .i_req  (w_req),
    .i_last (r_gnt),
    .o_vld  (w_vld),
    .o_gnt  (w_pick)
  );

  // Requests are only looked at in IDLE; a strobe still high in RESP is ignored.
  assign w_take = (r_state == IDLE) & w_vld;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_vld) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_gnt <= w_pick;
        r_adr <= w_pick ? m1_adr_i : m0_adr_i;
        r_dat <= w_pick ? m1_dat_i : m0_dat_i;
        r_we  <= w_pick ? m1_we_i  : m0_we_i;
      end
    end
  end

  // Address/data simply hold the latched values; only the write strobe is
  // qualified. rst gates it combinationally so a reset landing in ACCESS
  // cannot corrupt the RAM.
  assign ram_adr_o = r_adr;
  assign ram_dat_o = r_dat;
  assign ram_we_o  = (r_state == ACCESS) & r_we & ~rst;

  assign m0_ack_o  = (r_state == RESP) & (r_gnt == 1'(M0)) & ~rst;
  assign m1_ack_o  = (r_state == RESP) & (r_gnt == 1'(M1)) & ~rst;
  assign m0_dat_o  = ram_dat_i;
  assign m1_dat_o  = ram_dat_i;
  assign gnt_o     = r_gnt;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;
  import wb_arb_pkg::*;

`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [9:0]  m0_adr, m1_adr, ram_adr;
  logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, ram_wdat, ram_q;
  logic        m0_ack, m1_ack, ram_we, gnt;

  // behavioural RAM: registered read, read-before-write, plus a preload port
  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_adr;
  logic [31:0] pre_dat;

  always_ff @(posedge clk) begin
    if (pre_we) mem[pre_adr] <= pre_dat;
    else if (ram_we) mem[ram_adr] <= ram_wdat;
    ram_q <= mem[ram_adr];
  end

  always #5 clk = ~clk;

  wb_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .ram_adr_o(ram_adr), .ram_dat_o(ram_wdat), .ram_we_o(ram_we),
    .ram_dat_i(ram_q), .gnt_o(gnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_adr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // m0 single read: request, ACCESS, RESP(ack), back to IDLE
  task automatic m0_read(input string tag, input logic [9:0] a, input logic [31:0] exp);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = a;
    @(negedge clk);
    chk({tag, "_access_ack"}, 32'(m0_ack), 32'd0);
    chk({tag, "_access_adr"}, 32'(ram_adr), 32'(a));
    @(negedge clk);
    chk({tag, "_ack"},      32'(m0_ack), 32'd1);
    chk({tag, "_m1_ack"},   32'(m1_ack), 32'd0);
    chk({tag, "_data"},     m0_rdat,     exp);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_drop"}, 32'(m0_ack), 32'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; pre_we = 1'b0; pre_adr = '0; pre_dat = '0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0;
    @(negedge clk);
    preload(10'h005, 32'hDEADBEEF);
    preload(10'h010, 32'h11111111);
    preload(10'h3FF, 32'h00000000);

    // reset state
    chk("rst_m0_ack",  32'(m0_ack),  32'd0);
    chk("rst_m1_ack",  32'(m1_ack),  32'd0);
    chk("rst_ram_we",  32'(ram_we),  32'd0);
    chk("rst_gnt",     32'(gnt),     32'd0);
    chk("rst_ram_adr", 32'(ram_adr), 32'd0);
    chk("rst_ram_dat", ram_wdat,     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // m0 read of preloaded word
    m0_read("rd005", 10'h005, 32'hDEADBEEF);

    // m1 write 0x3FF, ram_we must pulse exactly once
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 10'h3FF; m1_wdat = 32'h12345678;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ram_we) cnt++;
      if (i == 0) chk("wr_access_dat", ram_wdat, 32'h12345678);
      if (i == 1) begin
        chk("wr_m1_ack", 32'(m1_ack), 32'd1);
        chk("wr_m0_ack", 32'(m0_ack), 32'd0);
        chk("wr_gnt",    32'(gnt),    32'd1);
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
      end
    end
    chk("wr_we_pulses", 32'(cnt), 32'd1);
    m0_read("rd3ff", 10'h3FF, 32'h12345678);

    // both masters request continuously (last grant is m0 here)
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 10'h005;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 10'h010;
    for (int k = 0; k < 12; k++) begin
      logic e0, e1;
      @(negedge clk);
      e1 = (k % 3 == 1) && (!RR || ((k / 3) % 2 == 0));
      e0 = (k % 3 == 1) && RR && ((k / 3) % 2 == 1);
      chk($sformatf("cont_m1_ack_%0d", k), 32'(m1_ack), 32'(e1));
      chk($sformatf("cont_m0_ack_%0d", k), 32'(m0_ack), 32'(e0));
      chk($sformatf("cont_we_%0d", k),     32'(ram_we), 32'd0);
    end
    // now in IDLE; m1 drops and m0 must be served next round
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    chk("drop_m0_ack_access", 32'(m0_ack), 32'd0);
    @(negedge clk);
    chk("drop_m0_ack",  32'(m0_ack), 32'd1);
    chk("drop_m0_data", m0_rdat,     32'hDEADBEEF);
    chk("drop_gnt",     32'(gnt),    32'd0);
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);

    // write aborted by reset in ACCESS
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 10'h010; m1_wdat = 32'hAAAA5555;
    @(negedge clk);
    chk("abort_we_pre", 32'(ram_we), 32'd1);
    rst = 1'b1;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1;
    chk("abort_we_rst", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(dut.r_state), 32'(IDLE));
    chk("abort_m1_ack", 32'(m1_ack), 32'd0);
    chk("abort_m0_ack", 32'(m0_ack), 32'd0);
    @(negedge clk);
    chk("abort_m1_ack2", 32'(m1_ack), 32'd0);
    chk("abort_mem",     mem[10'h010], 32'h11111111);

    // late drop: stb held through the ack cycle must not trigger a second access
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 10'h005;
    @(negedge clk);
    @(negedge clk);
    chk("late_ack", 32'(m0_ack), 32'd1);
    @(negedge clk);
    chk("late_state", 32'(dut.r_state), 32'(IDLE));
    chk("late_ack_gone", 32'(m0_ack), 32'd0);
    m0_cyc = 0; m0_stb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("late_no_ack_%0d", i), 32'(m0_ack), 32'd0);
      chk($sformatf("late_no_we_%0d", i),  32'(ram_we), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
